// File: rtl/pipelined_data_memory.sv
// Byte-maskable single-port data memory with a fixed-latency response pipeline.
// After reset the array is zeroed one word per cycle before requests are accepted.
module pipelined_data_memory #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_mask,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);
    localparam int                NBYTES  = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_addr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                in_range;
    logic [ADDR_W-1:0]   rd_idx;
    logic                s0_vld;
    logic                s0_err;
    logic [DATA_W-1:0]   s0_dat;

    logic [READ_LAT:1]             vld_pipe;
    logic [READ_LAT:1]             err_pipe;
    logic [READ_LAT:1][DATA_W-1:0] dat_pipe;

    // req_ready is registered, so a stale 1 can linger into a reset cycle
    assign accept   = req_valid & req_ready & ~rst;
    assign in_range = {1'b0, req_addr} < DEPTH_V;
    assign rd_idx   = in_range ? req_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            clr_addr  <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (clr_addr == LAST) begin
                        state     <= RUN;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                RUN:     ;
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == INIT) begin
            mem[clr_addr] <= '0;
        end else if (accept && req_we && in_range) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (req_mask[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    // Stage 0: data is zero for stores and out-of-range requests
    assign s0_vld = accept;
    assign s0_err = accept & ~in_range;
    assign s0_dat = (accept && !req_we && in_range) ? mem[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= s0_vld;
            err_pipe[1] <= s0_err;
            dat_pipe[1] <= s0_dat;
            for (int s = 2; s <= READ_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                err_pipe[s] <= err_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign rsp_valid = vld_pipe[READ_LAT];
    assign rsp_err   = vld_pipe[READ_LAT] & err_pipe[READ_LAT];
    assign rsp_rdata = vld_pipe[READ_LAT] ? dat_pipe[READ_LAT] : '0;

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Drives a default instance and a DEPTH=200/READ_LAT=4 instance with the same
// requests and compares both against a per-cycle reference model.
module tb_pipelined_data_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_mask = '0;

    logic        ready_a, rsp_valid_a, rsp_err_a, done_a;
    logic [31:0] rdata_a;
    logic        ready_b, rsp_valid_b, rsp_err_b, done_b;
    logic [31:0] rdata_b;

    always #5 clk = ~clk;

    pipelined_data_memory u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .rsp_err(rsp_err_a), .init_done(done_a)
    );

    pipelined_data_memory #(.DATA_W(32), .DEPTH(200), .ADDR_W(8), .READ_LAT(4)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b), .rsp_err(rsp_err_b), .init_done(done_b)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        qa[$];
    rsp_t        qb[$];
    logic [31:0] mm [2][256];
    bit          run [2];
    int          clr [2];
    int          edge_n = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    logic        last_err_b = 1'b0;

    function automatic int dep(int j);
        return (j == 0) ? 256 : 200;
    endfunction

    function automatic int lat(int j);
        return (j == 0) ? 1 : 4;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // One clock: advance the model on the current inputs, then compare outputs
    task automatic tick();
        rsp_t  r;
        rsp_t  e;
        logic  ev;
        string p;
        @(posedge clk);
        edge_n++;
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                run[j] = 1'b0;
                clr[j] = 0;
                if (j == 0) qa.delete(); else qb.delete();
            end else if (!run[j]) begin
                clr[j]++;
                if (clr[j] == dep(j)) begin
                    run[j] = 1'b1;
                    for (int k = 0; k < 256; k++) mm[j][k] = '0;
                end
            end else if (req_valid) begin
                r.due  = edge_n + lat(j) - 1;
                r.err  = int'(req_addr) >= dep(j);
                r.data = '0;
                if (!r.err) begin
                    if (req_we) begin
                        for (int b = 0; b < 4; b++)
                            if (req_mask[b]) mm[j][req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                    end else begin
                        r.data = mm[j][req_addr];
                    end
                end
                if (j == 0) qa.push_back(r); else qb.push_back(r);
            end
        end
        #1;
        for (int j = 0; j < 2; j++) begin
            ev = 1'b0;
            e.due = 0; e.err = 1'b0; e.data = '0;
            if (j == 0 && qa.size() > 0 && qa[0].due == edge_n) begin e = qa.pop_front(); ev = 1'b1; end
            if (j == 1 && qb.size() > 0 && qb[0].due == edge_n) begin e = qb.pop_front(); ev = 1'b1; end
            p = (j == 0) ? "a." : "b.";
            chk({p, "req_ready"}, 64'(j ? ready_b : ready_a), 64'(run[j]));
            chk({p, "init_done"}, 64'(j ? done_b : done_a), 64'(run[j]));
            chk({p, "rsp_valid"}, 64'(j ? rsp_valid_b : rsp_valid_a), 64'(ev));
            chk({p, "rsp_err"},   64'(j ? rsp_err_b : rsp_err_a), 64'(e.err));
            chk({p, "rsp_rdata"}, 64'(j ? rdata_b : rdata_a), 64'(e.data));
        end
        if (rsp_valid_a) last_a = rdata_a;
        if (rsp_valid_b) begin last_b = rdata_b; last_err_b = rsp_err_b; end
    endtask

    task automatic req(logic we, logic [7:0] a, logic [31:0] d, logic [3:0] m);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_mask = m;
        tick();
    endtask

    task automatic idle(int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Counts not-ready cycles after reset release while throwing junk at the inputs
    task automatic init_wait(string tag);
        int ca = 0;
        int cb = 0;
        int guard = 0;
        while (!(ready_a && ready_b) && guard < 1000) begin
            if (!ready_a) ca++;
            if (!ready_b) cb++;
            req_valid = ready_b ? 1'b0 : 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 8'($urandom);
            req_wdata = $urandom;
            req_mask  = 4'($urandom);
            tick();
            guard++;
        end
        chk({tag, ".init_len_a"}, 64'(ca), 64'd256);
        chk({tag, ".init_len_b"}, 64'(cb), 64'd200);
    endtask

    task automatic rand_traffic(int n);
        for (int i = 0; i < n; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_mask  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        init_wait("boot");

        for (int a = 0; a < 256; a++) req(1'b0, 8'(a), 32'h0, 4'h0);
        idle(5);

        req(1'b0, 8'h7F, 32'h0, 4'h0);
        idle(5);
        chk("ld7f", 64'(last_a), 64'h0);

        req(1'b1, 8'h10, 32'hAABBCCDD, 4'hF);
        req(1'b1, 8'h10, 32'h11223344, 4'h5);
        req(1'b0, 8'h10, 32'h0, 4'h0);
        idle(5);
        chk("merge_a", 64'(last_a), 64'hAA22CC44);
        chk("merge_b", 64'(last_b), 64'hAA22CC44);

        req(1'b1, 8'h20, 32'h12345678, 4'hF);
        req(1'b1, 8'h20, 32'hFFFFFFFF, 4'h0);
        idle(5);
        chk("mask0_rsp", 64'(last_a), 64'h0);
        req(1'b0, 8'h20, 32'h0, 4'h0);
        idle(5);
        chk("mask0_keep", 64'(last_a), 64'h12345678);

        for (int a = 1; a <= 3; a++) req(1'b1, 8'(a), 32'(a), 4'hF);
        for (int a = 1; a <= 3; a++) req(1'b0, 8'(a), 32'h0, 4'h0);
        idle(6);
        chk("lat4_last", 64'(last_b), 64'h3);

        req(1'b1, 8'd250, 32'hFFFFFFFF, 4'hF);
        req(1'b0, 8'd250, 32'h0, 4'h0);
        idle(6);
        chk("oor_err", 64'(last_err_b), 64'h1);
        chk("oor_data", 64'(last_b), 64'h0);

        rand_traffic(600);

        req(1'b0, 8'h10, 32'h0, 4'h0);
        req(1'b0, 8'h20, 32'h0, 4'h0);
        rst = 1'b1;
        req_valid = 1'b0;
        tick();
        rst = 1'b0;
        init_wait("rerun");
        for (int a = 0; a < 32; a++) req(1'b0, 8'(a), 32'h0, 4'h0);
        idle(5);

        rand_traffic(300);
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
